// File: rtl/bt656_stream_decoder.sv
// rtl/bt656_stream_decoder.sv - BT.656 byte stream to 16-bit YCbCr 4:2:2 pixel stream, one packet per field
// Optional XY protection-bit checking (adds err_prot) when BT656_PROT_CHECK_EN is defined.
module bt656_stream_decoder #(
   parameter int ACTIVE_WIDTH    = 720,
   parameter int LINES_PER_FIELD = 240
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  td_data,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        out_startofpacket,
   output logic        out_endofpacket,
   output logic        out_field,
   output logic        locked,
   output logic        err_short_line,
   output logic        overflow
`ifdef BT656_PROT_CHECK_EN
   ,
   output logic        err_prot
`endif
);

   localparam logic [10:0] B_MAX  = 11'(2 * ACTIVE_WIDTH);
   localparam logic [10:0] B_LAST = 11'(2 * ACTIVE_WIDTH - 1);
   localparam logic [9:0]  L_LIM  = 10'(LINES_PER_FIELD);
   localparam logic [9:0]  L_LAST = 10'(LINES_PER_FIELD - 1);

   typedef enum logic [1:0] {
      S_UNLOCKED = 2'd0,
      S_VBLANK   = 2'd1,
      S_ACTIVE   = 2'd2,
      S_HBLANK   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  d0_q, d1_q, d2_q, d3_q;
   logic [10:0] b_q, b_d;
   logic [9:0]  line_cnt_q, line_cnt_d;
   logic [7:0]  c_q, c_d;
   logic        cap_en_q, cap_en_d;
   logic [15:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic        field_q, field_d;
   logic        locked_q, locked_d;
   logic        short_q, short_d;
   logic        ovf_q, ovf_d;
   logic        prot_err_q, prot_err_d;

   logic preamble, prot_ok, xy_valid, xy_f, xy_v, xy_h, sav, eav;
   logic in_active, field_start, line_start, line_end;
   logic capture, emit;

   assign preamble = (d3_q == 8'hFF) && (d2_q == 8'h00) && (d1_q == 8'h00) && d0_q[7];
   assign xy_f     = d0_q[6];
   assign xy_v     = d0_q[5];
   assign xy_h     = d0_q[4];

`ifdef BT656_PROT_CHECK_EN
   assign prot_ok = (d0_q[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`else
   assign prot_ok = 1'b1;
`endif

   assign xy_valid = preamble && prot_ok;
   assign sav      = xy_valid && !xy_h;
   assign eav      = xy_valid && xy_h;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_UNLOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_UNLOCKED: if (xy_valid && xy_v) state_d = S_VBLANK;
         S_VBLANK:   if (sav && !xy_v) state_d = S_ACTIVE;
         S_ACTIVE: begin
            if (xy_valid && xy_v)  state_d = S_VBLANK;
            else if (eav)          state_d = S_HBLANK;
         end
         S_HBLANK: begin
            if (xy_valid && xy_v)  state_d = S_VBLANK;
            else if (sav)          state_d = S_ACTIVE;
         end
         default:                  state_d = S_UNLOCKED;
      endcase
   end

   always_comb begin
      in_active   = (state_q == S_ACTIVE);
      field_start = (state_q == S_VBLANK) && sav && !xy_v;
      line_start  = (state_q == S_HBLANK) && sav && !xy_v;
      line_end    = in_active && eav;
   end

   // 0xFF never occurs in BT.656 video data; it opens the next timing code, so capture stops there
   assign capture = in_active && !xy_valid && cap_en_q && (d0_q != 8'hFF);
   assign emit    = capture && b_q[0] && (b_q < B_MAX) && (line_cnt_q < L_LIM);

   always_comb begin
      b_d        = b_q;
      line_cnt_d = line_cnt_q;
      c_d        = c_q;
      cap_en_d   = cap_en_q;
      data_d     = data_q;
      valid_d    = emit;
      sop_d      = emit && (b_q == 11'd1) && (line_cnt_q == 10'd0);
      eop_d      = emit && (b_q == B_LAST) && (line_cnt_q == L_LAST);
      field_d    = field_q;
      locked_d   = locked_q;
      short_d    = line_end && (b_q < B_MAX);
      ovf_d      = ovf_q;
      prot_err_d = preamble && !prot_ok;

      if (field_start || line_start) begin
         cap_en_d = 1'b1;
         b_d      = 11'd0;
      end else if (in_active && !xy_valid && (d0_q == 8'hFF)) begin
         cap_en_d = 1'b0;
      end else if (capture) begin
         if (b_q < B_MAX) b_d = b_q + 11'd1;
         if (!b_q[0])     c_d = d0_q;
      end

      if (emit) data_d = {d0_q, c_q};

      if (field_start) begin
         line_cnt_d = 10'd0;
         field_d    = xy_f;
         locked_d   = 1'b1;
      end else if (line_start && (line_cnt_q != 10'h3FF)) begin
         line_cnt_d = line_cnt_q + 10'd1;
      end

      // A drop in the same cycle as a field start must still be reported
      if (valid_q && !out_ready) ovf_d = 1'b1;
      else if (field_start)      ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d0_q       <= 8'd0;
         d1_q       <= 8'd0;
         d2_q       <= 8'd0;
         d3_q       <= 8'd0;
         b_q        <= 11'd0;
         line_cnt_q <= 10'd0;
         c_q        <= 8'd0;
         cap_en_q   <= 1'b0;
         data_q     <= 16'd0;
         valid_q    <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         field_q    <= 1'b0;
         locked_q   <= 1'b0;
         short_q    <= 1'b0;
         ovf_q      <= 1'b0;
         prot_err_q <= 1'b0;
      end else begin
         d0_q       <= td_data;
         d1_q       <= d0_q;
         d2_q       <= d1_q;
         d3_q       <= d2_q;
         b_q        <= b_d;
         line_cnt_q <= line_cnt_d;
         c_q        <= c_d;
         cap_en_q   <= cap_en_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         field_q    <= field_d;
         locked_q   <= locked_d;
         short_q    <= short_d;
         ovf_q      <= ovf_d;
         prot_err_q <= prot_err_d;
      end
   end

   assign out_data          = data_q;
   assign out_valid         = valid_q;
   assign out_startofpacket = sop_q;
   assign out_endofpacket   = eop_q;
   assign out_field         = field_q;
   assign locked            = locked_q;
   assign err_short_line    = short_q;
   assign overflow          = ovf_q;

`ifdef BT656_PROT_CHECK_EN
   assign err_prot = prot_err_q;
`else
   logic unused_prot;
   assign unused_prot = prot_err_q;
`endif

endmodule

// File: tb/tb_bt656_stream_decoder.sv
// tb/tb_bt656_stream_decoder.sv - randomized self-checking bench for bt656_stream_decoder
// Reference model predicts pixels per line from the BT.656 line/field rules; build with BT656_PROT_CHECK_EN to cover err_prot.
module tb_bt656_stream_decoder;

   localparam int W = 4;
   localparam int L = 2;

   logic        clk;
   logic        reset_n;
   logic [7:0]  td_data;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic        out_field;
   logic        locked;
   logic        err_short_line;
   logic        overflow;
`ifdef BT656_PROT_CHECK_EN
   logic        err_prot;
   int          prot_seen = 0;
`endif

   bt656_stream_decoder #(.ACTIVE_WIDTH(W), .LINES_PER_FIELD(L)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .td_data           (td_data),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_field         (out_field),
      .locked            (locked),
      .err_short_line    (err_short_line),
      .overflow          (overflow)
`ifdef BT656_PROT_CHECK_EN
      ,
      .err_prot          (err_prot)
`endif
   );

   typedef struct {
      logic [15:0] data;
      logic        sop;
      logic        eop;
      logic        f;
      int          t;
   } pix_t;

   pix_t       exp_q[$];
   pix_t       mon_e;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         short_seen = 0;
   int         exp_short = 0;
   logic       drop_flag = 1'b0;
   int         low_pct = 0;
   logic [7:0] lbuf [0:3][0:11];
   int         llen [0:3];
   int         ldrop [0:3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (err_short_line) short_seen++;
`ifdef BT656_PROT_CHECK_EN
         if (err_prot) prot_seen++;
`endif
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("pix_unexpected", 32'(out_valid), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pix_data", 32'(out_data), 32'(mon_e.data));
               chk("pix_sop", 32'(out_startofpacket), 32'(mon_e.sop));
               chk("pix_eop", 32'(out_endofpacket), 32'(mon_e.eop));
               chk("pix_field", 32'(out_field), 32'(mon_e.f));
               chk("pix_cycle", 32'(cyc), 32'(mon_e.t));
               if (!out_ready) drop_flag = 1'b1;
            end
         end
      end
   end

   function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

   function automatic logic rdy(input int i, input int k);
      logic r;
      r = ($urandom_range(0, 99) >= low_pct);
      if (ldrop[i] >= 0 && k == 2 * ldrop[i] + 3) r = 1'b0;
      return r;
   endfunction

   task automatic put(input logic [7:0] b, input logic r);
      td_data   = b;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic put_xy(input logic [7:0] x);
      put(8'hFF, 1'b1);
      put(8'h00, 1'b1);
      put(8'h00, 1'b1);
      put(x, 1'b1);
   endtask

   task automatic filler(input int n);
      for (int j = 0; j < n; j++) put((j % 2 == 0) ? 8'h80 : 8'h10, 1'b1);
   endtask

   task automatic fill_line(input int i, input int n);
      for (int j = 0; j < n; j++) lbuf[i][j] = 8'($urandom_range(1, 254));
      llen[i]  = n;
      ldrop[i] = -1;
   endtask

   // Model: pixel p of line i is {byte 2p+1, byte 2p}, emitted two edges after its Y byte,
   // only for the first L lines and the first W pixels; fewer than W pixels is a short line.
   task automatic send_line(input logic f, input int i, input logic model,
                            input logic [7:0] sav, input logic send_eav);
      pix_t e;
      int   k;
      put_xy(sav);
      k = 0;
      for (int j = 0; j < llen[i]; j++) begin
         if (model && (j % 2 == 1) && (j / 2 < W) && (i < L)) begin
            e.data = {lbuf[i][j], lbuf[i][j-1]};
            e.sop  = (i == 0) && (j / 2 == 0);
            e.eop  = (i == L - 1) && (j / 2 == W - 1);
            e.f    = f;
            e.t    = cyc + 2;
            exp_q.push_back(e);
         end
         put(lbuf[i][j], rdy(i, k));
         k++;
      end
      if (send_eav) begin
         put(8'hFF, rdy(i, k)); k++;
         put(8'h00, rdy(i, k)); k++;
         put(8'h00, rdy(i, k)); k++;
         put(xy(f, 1'b0, 1'b1), rdy(i, k)); k++;
         if (model && (llen[i] / 2 < W)) exp_short++;
         for (int j = 0; j < 4; j++) begin
            put((j % 2 == 0) ? 8'h80 : 8'h10, rdy(i, k));
            k++;
         end
      end
   endtask

   task automatic run_field(input logic f, input int nl);
      drop_flag = 1'b0;
      filler(2);
      put_xy(xy(f, 1'b1, 1'b1));
      filler(4);
      for (int i = 0; i < nl; i++) send_line(f, i, 1'b1, xy(f, 1'b0, 1'b0), 1'b1);
      chk("overflow_field_end", 32'(overflow), 32'(drop_flag));
      chk("short_count", 32'(short_seen), 32'(exp_short));
      chk("locked", 32'(locked), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_sop"}, 32'(out_startofpacket), 32'd0);
      chk({tag, "_eop"}, 32'(out_endofpacket), 32'd0);
      chk({tag, "_field"}, 32'(out_field), 32'd0);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_short"}, 32'(err_short_line), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      logic [7:0] t1 [0:7];
      t1 = '{8'h10, 8'h20, 8'h30, 8'h21, 8'h40, 8'h22, 8'h50, 8'h23};
      reset_n   = 1'b0;
      td_data   = 8'h00;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         llen[i]  = 0;
         ldrop[i] = -1;
      end
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset_n = 1'b1;

      // Plan 1: two identical full lines, sop on first pixel, eop on eighth
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 8; j++) lbuf[i][j] = t1[j];
         llen[i]  = 8;
         ldrop[i] = -1;
      end
      run_field(1'b0, 2);

      // Plan 2: pixel 3 refused downstream
      ldrop[0] = 3;
      run_field(1'b0, 2);
      chk("overflow_sticky", 32'(overflow), 32'd1);

      // Plan 3: short last line, no eop; overflow cleared by the new field
      fill_line(0, 8);
      fill_line(1, 6);
      run_field(1'b1, 2);

      // Plan 4: third active line is discarded
      for (int i = 0; i < 3; i++) fill_line(i, 8);
      run_field(1'b0, 3);

      // Random fields: line count, line length, field bit and backpressure
      for (int n = 0; n < 10; n++) begin
         int nl;
         nl      = $urandom_range(1, 4);
         low_pct = ($urandom_range(0, 1) == 1) ? 25 : 0;
         for (int i = 0; i < nl; i++)
            fill_line(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * W - 1)
                                                     : 2 * W + $urandom_range(0, 2));
         run_field(1'($urandom_range(0, 1)), nl);
      end
      low_pct = 0;

      // Plan 5: reset in the middle of a line
      drop_flag = 1'b0;
      filler(2);
      put_xy(xy(1'b0, 1'b1, 1'b1));
      filler(2);
      fill_line(0, 5);
      send_line(1'b0, 0, 1'b1, xy(1'b0, 1'b0, 1'b0), 1'b0);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      chk("midreset_pending", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      fill_line(0, 8);
      send_line(1'b0, 0, 1'b0, xy(1'b0, 1'b0, 1'b0), 1'b1);
      chk("unlocked_after_reset", 32'(locked), 32'd0);
      fill_line(0, 8);
      fill_line(1, 8);
      run_field(1'b1, 2);

      // Plan 6: XY 0x81 carries bad protection bits
      drop_flag = 1'b0;
      filler(2);
      put_xy(xy(1'b0, 1'b1, 1'b1));
      filler(4);
      fill_line(0, 8);
`ifdef BT656_PROT_CHECK_EN
      send_line(1'b0, 0, 1'b0, 8'h81, 1'b1);
      chk("err_prot_count", 32'(prot_seen), 32'd1);
`else
      send_line(1'b0, 0, 1'b1, 8'h81, 1'b1);
`endif
      fill_line(0, 8);
      fill_line(1, 8);
      run_field(1'b0, 2);

      filler(4);
      chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
